// File: rtl/control_cmd_dispatch_pkg.sv
// Shared constants for the control command path: default handler count,
// opcode table and mid-command timeout.
package params;
  localparam int NUM_HANDLERS      = 4;
  localparam logic [7:0] WDOG_OPCODE = 8'h57;
  // Byte i is the opcode for handler i; the watchdog sits at handler 0.
  localparam logic [NUM_HANDLERS*8-1:0] CMD_OPCODES = {8'h44, 8'h43, 8'h42, WDOG_OPCODE};
  localparam int CMD_TIMEOUT_TICKS = 8;
endpackage

// File: rtl/control_cmd_dispatch_decode.sv
// Combinational priority match of one byte against the opcode table;
// the lowest matching handler index wins.
module control_cmd_decode #(
  parameter int NUM_HANDLERS = params::NUM_HANDLERS,
  parameter logic [NUM_HANDLERS*8-1:0] CMD_OPCODES = params::CMD_OPCODES
) (
  input  logic [7:0]                      byte_i,
  output logic                            hit_o,
  output logic [$clog2(NUM_HANDLERS)-1:0] index_o
);
  localparam int IDX_W = $clog2(NUM_HANDLERS);

  // Scan from the top down so the lowest index overwrites any higher match.
  always_comb begin
    hit_o   = 1'b0;
    index_o = '0;
    for (int i = NUM_HANDLERS - 1; i >= 0; i--) begin
      if (CMD_OPCODES[i*8 +: 8] == byte_i) begin
        hit_o   = 1'b1;
        index_o = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/control_cmd_dispatch.sv
// Opcode-driven router: forwards command payload bytes to one handler until
// it reports done, aborting handlers that stall mid-command.
module control_cmd_dispatch #(
  parameter int NUM_HANDLERS = params::NUM_HANDLERS,
  parameter logic [NUM_HANDLERS*8-1:0] CMD_OPCODES = params::CMD_OPCODES,
  parameter int CMD_TIMEOUT_TICKS = params::CMD_TIMEOUT_TICKS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      data_in,
  input  logic                            data_valid,
  input  logic [NUM_HANDLERS-1:0]         handler_done,
  output logic [7:0]                      data_out,
  output logic [NUM_HANDLERS-1:0]         handler_enable,
  output logic [NUM_HANDLERS-1:0]         handler_abort,
  output logic                            busy,
  output logic [$clog2(NUM_HANDLERS)-1:0] active_sel,
  output logic                            unknown_cmd,
  output logic                            timeout_err
);
  localparam int SEL_W = $clog2(NUM_HANDLERS);
  localparam int CNT_W = $clog2(CMD_TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CMD_TIMEOUT_TICKS);

  typedef enum logic {S_IDLE, S_ROUTE} ctrl_dispatch_fsm_t;

  ctrl_dispatch_fsm_t        state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [7:0]                data_q, data_d;
  logic [NUM_HANDLERS-1:0]   en_q, en_d, abort_q, abort_d;
  logic                      busy_q, busy_d, unk_q, unk_d, tmo_q, tmo_d;
  logic                      hit;
  logic [SEL_W-1:0]          hit_idx;
  logic                      sel_done;

  control_cmd_decode #(
    .NUM_HANDLERS (NUM_HANDLERS),
    .CMD_OPCODES  (CMD_OPCODES)
  ) u_decode (
    .byte_i  (data_in),
    .hit_o   (hit),
    .index_o (hit_idx)
  );

  assign sel_done = handler_done[sel_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    data_d  = data_q;
    busy_d  = busy_q;
    en_d    = '0;
    abort_d = '0;
    unk_d   = 1'b0;
    tmo_d   = 1'b0;
    if (state_q == S_ROUTE && !sel_done) begin
      // A byte always beats an expiring counter.
      if (data_valid) begin
        data_d = data_in;
        en_d   = NUM_HANDLERS'(1) << sel_q;
        cnt_d  = CNT_LOAD;
      end else if (cnt_q == '0) begin
        abort_d = NUM_HANDLERS'(1) << sel_q;
        tmo_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      // Idle, or the routed handler just finished: the incoming byte is an opcode.
      if (state_q == S_ROUTE) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      if (data_valid) begin
        if (hit) begin
          sel_d   = hit_idx;
          busy_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_ROUTE;
        end else begin
          unk_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_LOAD;
      sel_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= '0;
      abort_q <= '0;
      unk_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      abort_q <= abort_d;
      unk_q   <= unk_d;
      tmo_q   <= tmo_d;
    end
  end

  assign data_out       = data_q;
  assign handler_enable = en_q;
  assign handler_abort  = abort_q;
  assign busy           = busy_q;
  assign active_sel     = sel_q;
  assign unknown_cmd    = unk_q;
  assign timeout_err    = tmo_q;
endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Scoreboard bench for control_cmd_dispatch: a command-level reference model
// predicts every output cycle; a monitor compares after each clock edge.
module tb_control_cmd_dispatch;
  localparam int N = 4;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic [N-1:0] handler_done = '0;
  logic [7:0] data_out;
  logic [N-1:0] handler_enable, handler_abort;
  logic       busy, unknown_cmd, timeout_err;
  logic [1:0] active_sel;

  control_cmd_dispatch #(
    .NUM_HANDLERS      (N),
    .CMD_OPCODES       ({8'h44, 8'h43, 8'h42, 8'h57}),
    .CMD_TIMEOUT_TICKS (T)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .handler_done   (handler_done),
    .data_out       (data_out),
    .handler_enable (handler_enable),
    .handler_abort  (handler_abort),
    .busy           (busy),
    .active_sel     (active_sel),
    .unknown_cmd    (unknown_cmd),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   data;
    logic [N-1:0] en;
    logic [N-1:0] abort;
    logic         busy;
    logic [1:0]   sel;
    logic         unk;
    logic         tmo;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] ops [N] = '{8'h57, 8'h42, 8'h43, 8'h44};

  // Reference model: a command is "open" until its handler is done or it has
  // gone more than T consecutive cycles without a byte.
  bit   m_open = 0;
  int   m_sel = 0;
  int   m_quiet = 0;
  logic [7:0] m_data = '0;

  task automatic cyc(input bit rst_n, input bit dv, input logic [7:0] d, input logic [N-1:0] done);
    exp_t e;
    int   found;
    reset = rst_n; data_valid = dv; data_in = d; handler_done = done;
    e = '0;
    if (!rst_n) begin
      m_open = 0; m_sel = 0; m_data = '0; m_quiet = 0;
    end else if (m_open && !done[m_sel]) begin
      if (dv) begin
        m_data = d; e.en[m_sel] = 1'b1; m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet > T) begin
          e.abort[m_sel] = 1'b1; e.tmo = 1'b1; m_open = 0;
        end
      end
    end else begin
      m_open = 0;
      if (dv) begin
        found = -1;
        for (int i = 0; i < N; i++) if (found < 0 && ops[i] == d) found = i;
        if (found >= 0) begin
          m_open = 1; m_sel = found; m_quiet = 0;
        end else e.unk = 1'b1;
      end
    end
    e.busy = m_open; e.sel = 2'(m_sel); e.data = m_data;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 8'h00, '0);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      chk("data_out", data_out, e.data);
      chk("handler_enable", 8'(handler_enable), 8'(e.en));
      chk("handler_abort", 8'(handler_abort), 8'(e.abort));
      chk("busy", 8'(busy), 8'(e.busy));
      if (e.busy) chk("active_sel", 8'(active_sel), 8'(e.sel));
      chk("unknown_cmd", 8'(unknown_cmd), 8'(e.unk));
      chk("timeout_err", 8'(timeout_err), 8'(e.tmo));
    end
  end

  initial begin
    int r;
    @(negedge clk);
    cyc(0, 0, 8'h00, '0);
    cyc(0, 0, 8'h00, '0);
    idle(2);
    // Basic routing to handler 1.
    cyc(1, 1, 8'h42, '0);
    cyc(1, 1, 8'hAA, '0);
    idle(1);
    cyc(1, 1, 8'hBB, '0);
    cyc(1, 0, 8'h00, 4'b0010);
    idle(2);
    // Unknown opcode then route to handler 0.
    cyc(1, 1, 8'h99, '0);
    idle(1);
    cyc(1, 1, 8'h57, '0);
    cyc(1, 1, 8'h01, '0);
    // Back-to-back: done and next opcode together.
    cyc(1, 1, 8'h44, 4'b0001);
    cyc(1, 1, 8'h55, '0);
    cyc(1, 0, 8'h00, 4'b1000);
    // Timeout on handler 2.
    cyc(1, 1, 8'h43, '0);
    cyc(1, 1, 8'h11, '0);
    idle(T + 3);
    // Byte on the counter-zero cycle suppresses abort; then done on expiry wins.
    cyc(1, 1, 8'h43, '0);
    idle(T);
    cyc(1, 1, 8'h22, '0);
    idle(T);
    cyc(1, 0, 8'h00, 4'b0100);
    idle(1);
    // Ignored foreign done, then reset mid-route.
    cyc(1, 1, 8'h42, '0);
    cyc(1, 0, 8'h00, 4'b0100);
    cyc(1, 1, 8'h33, '0);
    cyc(0, 0, 8'h00, '0);
    idle(T + 3);
    // Watchdog-style command: signature bytes to handler 0, then its done.
    cyc(1, 1, 8'h57, '0);
    cyc(1, 1, 8'hA5, '0);
    cyc(1, 1, 8'h5A, '0);
    idle(2);
    cyc(1, 0, 8'h00, 4'b0001);
    idle(1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0]   d;
      logic [N-1:0] dn;
      bit           dv;
      r  = $urandom_range(0, 99);
      dv = ($urandom_range(0, 99) < 40);
      d  = ($urandom_range(0, 2) == 0) ? ops[$urandom_range(0, N - 1)] : 8'($urandom);
      dn = ($urandom_range(0, 9) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      if (r == 0) cyc(0, dv, d, dn);
      else if (r < 4) idle($urandom_range(T - 1, T + 2));
      else cyc(1, dv, d, dn);
    end
    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/control_cmd_dispatch.md
# control_cmd_dispatch

Front-end sequencer for the control command path. Accepts the byte stream from the UART receiver, decodes the first byte of each command as an opcode, and routes the following bytes to exactly one command handler (e.g. `control_cmd_watchdog`) via per-handler enables. It holds the route until that handler reports `done`, and aborts a handler that stalls mid-command.

## Interface

Parameters:
- `NUM_HANDLERS`, default 4: number of downstream command handlers (≥2).
- `CMD_OPCODES`, default `params::CMD_OPCODES`: packed `[NUM_HANDLERS*8-1:0]`; byte i is the opcode for handler i.
- `CMD_TIMEOUT_TICKS`, default `params::CMD_TIMEOUT_TICKS`: idle cycles allowed mid-command before abort (≥2).

Ports:
- `clk` in 1: system clock; the block uses one clock.
- `reset` in 1: synchronous, active-low (0 = reset).
- `data_in` in 8: received byte.
- `data_valid` in 1: one-cycle strobe, `data_in` valid.
- `handler_done` in NUM_HANDLERS: one-cycle done pulse from each handler.
- `data_out` out 8: registered byte to the handlers (shared bus).
- `handler_enable` out NUM_HANDLERS: one-hot byte strobe to the selected handler.
- `handler_abort` out NUM_HANDLERS: one-hot, one-cycle abort to the selected handler (handler ORs into its reset).
- `busy` out 1: high while a command is routed.
- `active_sel` out `$clog2(NUM_HANDLERS)`: index of the routed handler; valid while `busy`.
- `unknown_cmd` out 1: one-cycle pulse on an unmatched opcode.
- `timeout_err` out 1: one-cycle pulse on abort.

## Operation

- States: `S_IDLE`, `S_ROUTE`.
- **S_IDLE:**
  - On `data_valid`, compare `data_in` against all `CMD_OPCODES` entries.
  - Match: latch the lowest matching index into `active_sel`, set `busy`, load the timeout counter to `CMD_TIMEOUT_TICKS`, go to `S_ROUTE`. The opcode byte is not forwarded.
  - No match: pulse `unknown_cmd` and stay in `S_IDLE`.
- **S_ROUTE:**
  - On `data_valid`, register `data_in` into `data_out`, pulse `handler_enable[active_sel]`, and reload the timeout counter.
  - On `handler_done[active_sel]`, clear `busy` and go to `S_IDLE`.
  - `handler_done` from non-selected handlers is ignored in every state.
  - If there is no byte and no done, decrement the counter. When the counter is 0, pulse `handler_abort[active_sel]` and `timeout_err`, clear `busy`, and go to `S_IDLE`.
- **Simultaneous events in S_ROUTE:**
  - Done and `data_valid` in the same cycle: done wins. The byte is decoded as a new opcode in that same cycle, with S_IDLE rules applied, so back-to-back commands lose no byte.
  - Counter at 0 and `data_valid` in the same cycle: the byte is forwarded, the counter reloads, and there is no abort.
  - Counter at 0 and done in the same cycle: done wins, with no abort and no `timeout_err`.
- `data_out` holds its last value when not strobed.
- Timeout counter width is `$clog2(CMD_TIMEOUT_TICKS+1)`. It saturates at 0 and never wraps.

## Timing

- **Reset values:**
  - `data_out`=0, `handler_enable`=0, `handler_abort`=0, `busy`=0, `active_sel`=0, `unknown_cmd`=0, `timeout_err`=0.
  - State `S_IDLE`, counter=`CMD_TIMEOUT_TICKS`.
- All outputs are registered.
- Opcode `data_valid` at cycle t → `busy`/`active_sel` valid at t+1.
- Payload `data_valid` at t → `handler_enable`/`data_out` at t+1. Latency is exactly 1 and every byte is forwarded; no backpressure.
- `handler_done` at t → `busy`=0 at t+1.
- Timeout: with the last reload at edge t and no byte or done afterward, abort and `timeout_err` are high during cycle t+CMD_TIMEOUT_TICKS+1 for exactly one cycle.
- Reset asserted mid-route: return to `S_IDLE` on the next edge with no abort pulse; handlers are reset by the same system reset.
- `unknown_cmd` appears at t+1 and lasts one cycle.

## Structure

- In `params`: `CMD_OPCODES`, `CMD_TIMEOUT_TICKS`, default `NUM_HANDLERS`, and the opcode for the watchdog handler.
- `ctrl_dispatch_fsm_t` (`S_IDLE`, `S_ROUTE`) stays local to the module.
- One natural sub-module, `control_cmd_decode`: combinational priority match of a byte against the opcode table. It outputs `hit` and `index` (lowest index wins) and is reusable and unit-testable on its own.

## Test plan

- **Basic routing:** NUM_HANDLERS=4, opcodes {0x57,0x42,0x43,0x44}. Send 0x42, then 0xAA and 0xBB, then pulse `handler_done[1]`.
  - Required: `active_sel`=1; `handler_enable`=4'b0010 with `data_out` 0xAA then 0xBB, each one cycle after its strobe.
  - `busy` falls one cycle after done; `handler_enable[0,2,3]` never assert.
- **Unknown opcode:** send 0x99 → `unknown_cmd` pulses once at t+1, `busy` stays 0, and the next 0x57 routes to handler 0.
- **Timeout:** CMD_TIMEOUT_TICKS=8. Send 0x43 and one payload byte, then idle.
  - Required: `handler_abort`=4'b0100 and `timeout_err` pulse exactly 9 cycles after the payload strobe edge, then `busy`=0.
  - A payload byte landing on the counter=0 cycle suppresses the abort.
- **Back-to-back:** `handler_done[0]` and `data_valid`=0x44 in the same cycle → no byte lost; `active_sel`=3 and `busy`=1 on the next cycle.
- **Ignored done and reset:**
  - `handler_done[2]` while routed to handler 1 → no effect.
  - `reset`=0 mid-route → all outputs 0 next cycle and no `handler_abort` pulse.
- **Watchdog integration:** route to `control_cmd_watchdog` with its signature bytes → the watchdog counter reloads, its `done` returns the dispatcher to IDLE, and `sys_reset` never asserts.
